// File: rtl/dec38_pkg.sv
// Shared types and constants for the 3-to-8 sweep decoder.
// Holds the FSM state encoding and the active-low 7-segment patterns
// (dp in bit 7, gfedcba in bits 6..0) for octal digits 0..7.
package dec38_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_oct.sv
// Combinational octal-digit to active-low 7-segment pattern (dp held off).
module seg7_oct
    import dec38_pkg::*;
(
    input  logic [2:0] code_i,
    output logic [7:0] seg_o
);

    // Straight lookup of the digit glyph.
    always_comb begin
        seg_o = SEG_BLANK;
        unique case (code_i)
            3'd0: seg_o = SEG_0;
            3'd1: seg_o = SEG_1;
            3'd2: seg_o = SEG_2;
            3'd3: seg_o = SEG_3;
            3'd4: seg_o = SEG_4;
            3'd5: seg_o = SEG_5;
            3'd6: seg_o = SEG_6;
            3'd7: seg_o = SEG_7;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/dec38_sweep.sv
// 3-to-8 decoder with a walking one-hot sweep up to the accepted code.
// A code is taken over a valid/ready handshake, the lit bit walks from bit 0
// to bit <code> at STEP_CYCLES per position, holds HOLD_CYCLES, then pulses
// done in the first idle cycle. Dropping en aborts without a done pulse.
// Optional: define DEC38_SEG_EN to add seg_out_o, a registered active-low
// 7-segment digit of the latched code (blank while idle).
module dec38_sweep
    import dec38_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       in_valid_i,
    input  logic [2:0] in_code_i,
    output logic       in_ready_o,
    output logic [7:0] onehot_o,
    output logic       busy_o,
    output logic       done_o
`ifdef DEC38_SEG_EN
    ,
    output logic [7:0] seg_out_o
`endif
);

    localparam int unsigned MaxCycles = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
    localparam logic [TimerW-1:0] StepLast = TimerW'(STEP_CYCLES - 1);
    localparam logic [TimerW-1:0] HoldLast = TimerW'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        code_q, code_d;
    logic [7:0]        onehot_q, onehot_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              done_q, done_d;
    logic [7:0]        shifted;
    logic [7:0]        target;

`ifdef DEC38_SEG_EN
    logic [7:0] seg_q, seg_d;
    logic [7:0] seg_pat;

    seg7_oct u_seg7_oct (
        .code_i (in_code_i),
        .seg_o  (seg_pat)
    );
`endif

    assign in_ready_o = (state_q == StIdle) && en_i;
    assign busy_o     = (state_q != StIdle);
    assign onehot_o   = onehot_q;
    assign done_o     = done_q;
`ifdef DEC38_SEG_EN
    assign seg_out_o  = seg_q;
`endif

    // Next-state logic: accept, walk one position per STEP_CYCLES, hold, finish.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        onehot_d = onehot_q;
        timer_d  = timer_q;
        done_d   = 1'b0;
`ifdef DEC38_SEG_EN
        seg_d    = seg_q;
`endif
        shifted  = {onehot_q[6:0], 1'b0};
        target   = 8'h01 << code_q;

        if (!en_i) begin
            // Abort path: blank and idle, deliberately no done pulse.
            state_d  = StIdle;
            onehot_d = '0;
            timer_d  = '0;
`ifdef DEC38_SEG_EN
            seg_d    = SEG_BLANK;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    onehot_d = '0;
                    if (in_valid_i) begin
                        code_d   = in_code_i;
                        onehot_d = 8'h01;
                        timer_d  = '0;
                        state_d  = (in_code_i == 3'd0) ? StHold : StSweep;
`ifdef DEC38_SEG_EN
                        seg_d    = seg_pat;
`endif
                    end
                end
                StSweep: begin
                    if (timer_q == StepLast) begin
                        timer_d  = '0;
                        onehot_d = shifted;
                        if (shifted == target) begin
                            state_d = StHold;
                        end
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                StHold: begin
                    if (timer_q == HoldLast) begin
                        state_d  = StIdle;
                        onehot_d = '0;
                        done_d   = 1'b1;
                        timer_d  = '0;
`ifdef DEC38_SEG_EN
                        seg_d    = SEG_BLANK;
`endif
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                default: begin
                    state_d  = StIdle;
                    onehot_d = '0;
                    timer_d  = '0;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            code_q   <= '0;
            onehot_q <= '0;
            timer_q  <= '0;
            done_q   <= 1'b0;
`ifdef DEC38_SEG_EN
            seg_q    <= SEG_BLANK;
`endif
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            onehot_q <= onehot_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
`ifdef DEC38_SEG_EN
            seg_q    <= seg_d;
`endif
        end
    end

endmodule

// File: tb/tb_dec38_sweep.sv
// Scoreboard bench for dec38_sweep: each accepted code pushes its full
// per-cycle expected trace; a negedge monitor pops one entry per cycle.
module tb_dec38_sweep;

    localparam int unsigned S = 4;
    localparam int unsigned H = 8;

    typedef struct packed {
        logic [7:0] oh;
        logic       done;
        logic       busy;
        logic [7:0] seg;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic       in_valid_i;
    logic [2:0] in_code_i;
    logic       in_ready_o;
    logic [7:0] onehot_o;
    logic       busy_o;
    logic       done_o;
`ifdef DEC38_SEG_EN
    logic [7:0] seg_out_o;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    dec38_sweep #(
        .STEP_CYCLES (S),
        .HOLD_CYCLES (H)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .in_valid_i (in_valid_i),
        .in_code_i  (in_code_i),
        .in_ready_o (in_ready_o),
        .onehot_o   (onehot_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef DEC38_SEG_EN
        ,
        .seg_out_o  (seg_out_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Glyph built from lit segments (active high gfedcba), then inverted.
    function automatic logic [7:0] seg_of(input int d);
        logic [6:0] lit [8];
        lit[0] = 7'h3F; lit[1] = 7'h06; lit[2] = 7'h5B; lit[3] = 7'h4F;
        lit[4] = 7'h66; lit[5] = 7'h6D; lit[6] = 7'h7D; lit[7] = 7'h07;
        return {1'b1, ~lit[d]};
    endfunction

    function automatic exp_t mk(input logic [7:0] oh, input logic dn, input logic bz,
                                input logic [7:0] sg);
        exp_t e;
        e.oh = oh; e.done = dn; e.busy = bz; e.seg = sg;
        return e;
    endfunction

    // Expected cycles 1 .. c*S+H+1 after an accept of code c.
    task automatic push_trace(input int c);
        for (int k = 0; k < c; k++)
            for (int s = 0; s < int'(S); s++) exp_q.push_back(mk(8'(1 << k), 1'b0, 1'b1, seg_of(c)));
        for (int s = 0; s < int'(H); s++) exp_q.push_back(mk(8'(1 << c), 1'b0, 1'b1, seg_of(c)));
        exp_q.push_back(mk(8'h00, 1'b1, 1'b0, 8'hFF));
    endtask

    // Monitor: one expected entry per cycle, idle values when nothing is queued.
    always @(negedge clk_i) begin
        exp_t e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(8'h00, 1'b0, 1'b0, 8'hFF);
        check("onehot", onehot_o, e.oh);
        check("done", 8'(done_o), 8'(e.done));
        check("busy", 8'(busy_o), 8'(e.busy));
        check("in_ready", 8'(in_ready_o), 8'(en_i && !e.busy));
`ifdef DEC38_SEG_EN
        check("seg_out", seg_out_o, e.seg);
`endif
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Idle cycles; en may drop, and valid is only offered while en is low.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            en_i       = 1'($urandom_range(1));
            in_valid_i = en_i ? 1'b0 : 1'($urandom_range(1));
            in_code_i  = 3'($urandom_range(7));
            next_cycle();
        end
        en_i       = 1'b1;
        in_valid_i = 1'b0;
    endtask

    // One transaction from a cycle where the block is ready. kind: 0 none,
    // 1 drop en at cycle abort_at, 2 async reset during cycle abort_at.
    task automatic run(input int c, input int kind, input int abort_at);
        int len;
        en_i       = 1'b1;
        in_valid_i = 1'b1;
        in_code_i  = 3'(c);
        next_cycle();
        push_trace(c);
        len = c * int'(S) + int'(H);
        for (int cyc = 1; cyc <= len; cyc++) begin
            in_valid_i = 1'($urandom_range(1));
            in_code_i  = 3'($urandom_range(7));
            if (kind == 1 && cyc == abort_at) begin
                en_i = 1'b0;
                next_cycle();
                exp_q.delete();
                next_cycle();
                en_i       = 1'b1;
                in_valid_i = 1'b0;
                return;
            end
            if (kind == 2 && cyc == abort_at) begin
                #2;
                rst_ni = 1'b0;
                exp_q.delete();
                #1;
                check("rst_onehot", onehot_o, 8'h00);
                check("rst_busy", 8'(busy_o), 8'h00);
                en_i       = 1'b1;
                in_valid_i = 1'b1;
                in_code_i  = 3'($urandom_range(7));
                next_cycle();
                next_cycle();
                rst_ni = 1'b1;
                return;
            end
            next_cycle();
        end
        in_valid_i = 1'b0;
    endtask

    initial begin
        int c;
        int len;
        rst_ni     = 1'b0;
        en_i       = 1'b1;
        in_valid_i = 1'b1;
        in_code_i  = 3'd4;
        repeat (2) next_cycle();
        rst_ni = 1'b1;

        run(5, 0, 0);
        run(0, 0, 0);
        run(7, 0, 0);
        idle(2);
        run(3, 0, 0);
        run(6, 1, 10);
        run(2, 2, 12);
        run(1, 0, 0);

        for (int t = 0; t < 24; t++) begin
            c   = $urandom_range(7);
            len = c * int'(S) + int'(H);
            if ($urandom_range(1) == 1) idle($urandom_range(1, 3));
            case ($urandom_range(5))
                0:       run(c, 1, $urandom_range(1, len));
                1:       run(c, 2, $urandom_range(1, len));
                default: run(c, 0, 0);
            endcase
        end

        idle(3);
        en_i = 1'b1;
        next_cycle();
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
